// File: rtl/trng_reader.sv
// TRNG byte-stream consumer: sample divider, warm-up, repetition-count health test, word packing, output FIFO.
// Optional adaptive-proportion test is enabled by defining TRNG_APT_EN.
module trng_reader #(
   parameter int SAMPLE_DIV     = 8,
   parameter int WORD_BYTES     = 4,
   parameter int FIFO_DEPTH     = 4,
   parameter int WARMUP_SAMPLES = 16,
   parameter int RCT_CUTOFF     = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    enable,
   input  logic [7:0]              rng_byte,
   output logic [8*WORD_BYTES-1:0] out_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    alarm,
   input  logic                    alarm_clear,
   output logic [7:0]              drop_cnt
);
   localparam int DW = 8 * WORD_BYTES;
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int IW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
   localparam int WW = $clog2(WARMUP_SAMPLES + 1);
   localparam int RW = $clog2(RCT_CUTOFF + 1);

   typedef enum logic [1:0] {S_IDLE, S_WARMUP, S_COLLECT, S_FAIL} state_t;

   state_t          state_q, state_d;
   logic [7:0]      div_q, div_d;
   logic [WW-1:0]   warm_q, warm_d;
   logic [7:0]      prev_q, prev_d;
   logic [RW-1:0]   rep_q, rep_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [DW-1:0]   word_q, word_d;
   logic            push_q, push_d;
   logic [DW-1:0]   push_word_q, push_word_d;
   logic [DW-1:0]   mem_q [FIFO_DEPTH];
   logic [DW-1:0]   mem_d [FIFO_DEPTH];
   logic [PW-1:0]   wr_q, wr_d, rd_q, rd_d;
   logic [PW:0]     cnt_q, cnt_d, cnt_pop;
   logic [DW-1:0]   out_data_q, out_data_d;
   logic            out_valid_q, out_valid_d;
   logic            alarm_q, alarm_d;
   logic [7:0]      drop_q, drop_d;

   logic            strobe, sampling, pop, trip, apt_trip;
   logic [RW-1:0]   rep_next;

`ifdef TRNG_APT_EN
   logic [5:0]      apt_idx_q, apt_idx_d;
   logic [7:0]      apt_val_q, apt_val_d;
   logic [6:0]      apt_hits_q, apt_hits_d;
`endif

   // Next-state logic: sampling, health tests, FSM, packing and FIFO bookkeeping
   always_comb begin
      state_d     = state_q;
      div_d       = div_q;
      warm_d      = warm_q;
      prev_d      = prev_q;
      rep_d       = rep_q;
      idx_d       = idx_q;
      word_d      = word_q;
      push_d      = 1'b0;
      push_word_d = push_word_q;
      mem_d       = mem_q;
      wr_d        = wr_q;
      rd_d        = rd_q;
      drop_d      = drop_q;
      alarm_d     = alarm_q;
      apt_trip    = 1'b0;

      strobe   = (state_q != S_IDLE) && (div_q == 8'(SAMPLE_DIV - 1));
      sampling = strobe && ((state_q == S_WARMUP) || (state_q == S_COLLECT));
      if (state_q == S_IDLE || strobe) begin
         div_d = 8'd0;
      end else begin
         div_d = div_q + 8'd1;
      end

      rep_next = (rng_byte == prev_q) ? rep_q + RW'(1) : RW'(1);
      if (sampling) begin
         prev_d = rng_byte;
         rep_d  = rep_next;
      end

`ifdef TRNG_APT_EN
      apt_idx_d  = apt_idx_q;
      apt_val_d  = apt_val_q;
      apt_hits_d = apt_hits_q;
      if (sampling) begin
         // The first sample of each 64-sample window sets the value being counted
         if (apt_idx_q == 6'd0) begin
            apt_val_d  = rng_byte;
            apt_hits_d = 7'd1;
         end else if (rng_byte == apt_val_q) begin
            apt_hits_d = apt_hits_q + 7'd1;
         end else begin
            apt_hits_d = apt_hits_q;
         end
         apt_idx_d = apt_idx_q + 6'd1;
         apt_trip  = (apt_hits_d >= 7'd40);
      end
`endif
      trip = sampling && ((rep_next >= RW'(RCT_CUTOFF)) || apt_trip);

      case (state_q)
         S_IDLE: begin
            if (enable && !alarm_q) begin
               state_d = S_WARMUP;
               prev_d  = 8'd0;
               rep_d   = '0;
               warm_d  = '0;
               idx_d   = '0;
`ifdef TRNG_APT_EN
               apt_idx_d = 6'd0;
`endif
            end
         end
         S_WARMUP: begin
            if (!enable) begin
               state_d = S_IDLE;
            end else if (trip) begin
               state_d = S_FAIL;
               alarm_d = 1'b1;
            end else if (strobe) begin
               if (warm_q == WW'(WARMUP_SAMPLES - 1)) begin
                  state_d = S_COLLECT;
                  idx_d   = '0;
               end else begin
                  warm_d = warm_q + WW'(1);
               end
            end
         end
         S_COLLECT: begin
            if (!enable) begin
               state_d = S_IDLE;
               idx_d   = '0;
            end else if (trip) begin
               state_d = S_FAIL;
               alarm_d = 1'b1;
               idx_d   = '0;
            end else if (strobe) begin
               word_d[{idx_q, 3'b000} +: 8] = rng_byte;
               if (idx_q == IW'(WORD_BYTES - 1)) begin
                  idx_d       = '0;
                  push_d      = 1'b1;
                  push_word_d = word_d;
               end else begin
                  idx_d = idx_q + IW'(1);
               end
            end
         end
         S_FAIL: begin
            if (alarm_clear) begin
               state_d = S_IDLE;
               alarm_d = 1'b0;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // A pop in the same cycle frees a slot before the pending push is considered
      pop     = out_valid_q && out_ready;
      cnt_pop = cnt_q - (PW+1)'(pop);
      if (pop) begin
         rd_d = rd_q + PW'(1);
      end
      cnt_d = cnt_pop;
      if (push_q) begin
         if (cnt_pop < (PW+1)'(FIFO_DEPTH)) begin
            mem_d[wr_q] = push_word_q;
            wr_d        = wr_q + PW'(1);
            cnt_d       = cnt_pop + (PW+1)'(1);
         end else if (drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
         end else begin
            drop_d = drop_q;
         end
      end

      out_valid_d = (cnt_d != '0);
      out_data_d  = out_valid_d ? mem_d[rd_d] : '0;
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         div_q       <= 8'd0;
         warm_q      <= '0;
         prev_q      <= 8'd0;
         rep_q       <= '0;
         idx_q       <= '0;
         word_q      <= '0;
         push_q      <= 1'b0;
         push_word_q <= '0;
         mem_q       <= '{default: '0};
         wr_q        <= '0;
         rd_q        <= '0;
         cnt_q       <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         alarm_q     <= 1'b0;
         drop_q      <= 8'd0;
`ifdef TRNG_APT_EN
         apt_idx_q   <= 6'd0;
         apt_val_q   <= 8'd0;
         apt_hits_q  <= 7'd0;
`endif
      end else begin
         state_q     <= state_d;
         div_q       <= div_d;
         warm_q      <= warm_d;
         prev_q      <= prev_d;
         rep_q       <= rep_d;
         idx_q       <= idx_d;
         word_q      <= word_d;
         push_q      <= push_d;
         push_word_q <= push_word_d;
         mem_q       <= mem_d;
         wr_q        <= wr_d;
         rd_q        <= rd_d;
         cnt_q       <= cnt_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         alarm_q     <= alarm_d;
         drop_q      <= drop_d;
`ifdef TRNG_APT_EN
         apt_idx_q   <= apt_idx_d;
         apt_val_q   <= apt_val_d;
         apt_hits_q  <= apt_hits_d;
`endif
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign alarm     = alarm_q;
   assign drop_cnt  = drop_q;
endmodule

// File: tb/tb_trng_reader.sv
// Scoreboard bench for trng_reader: directed byte streams, expected words queued, monitor compares on transfer.
module tb_trng_reader;
   logic        clk;
   logic        reset;
   logic        enable;
   logic [7:0]  rng_byte;
   logic [31:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic        alarm;
   logic        alarm_clear;
   logic [7:0]  drop_cnt;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_q[$];
   logic        stall_v;
   logic [31:0] stall_d;

   trng_reader dut (
      .clk(clk), .reset(reset), .enable(enable), .rng_byte(rng_byte),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .alarm(alarm), .alarm_clear(alarm_clear), .drop_cnt(drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: compares each transfer against the scoreboard and checks stall stability
   initial begin
      stall_v = 1'b0;
      stall_d = 32'h0;
      forever begin
         @(negedge clk);
         #2;
         if (reset) begin
            stall_v = 1'b0;
         end else begin
            if (stall_v && out_valid) chk("stall_stable", out_data, stall_d);
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_word: got %h expected none", out_data);
               end else begin
                  chk("word", out_data, exp_q.pop_front());
               end
               stall_v = 1'b0;
            end else if (out_valid) begin
               stall_v = 1'b1;
               stall_d = out_data;
            end else begin
               stall_v = 1'b0;
            end
         end
      end
   end

   // Present one byte for a whole sample period; returns on the sampling edge
   task automatic feed(input logic [7:0] b);
      @(negedge clk);
      rng_byte = b;
      repeat (8) @(posedge clk);
   endtask

   task automatic feed_ramp(input logic [7:0] base, input int n);
      for (int i = 0; i < n; i++) feed(base + 8'(i));
   endtask

   task automatic start_run();
      @(negedge clk);
      enable = 1'b1;
      @(posedge clk);
   endtask

   task automatic stop_run();
      @(negedge clk);
      enable = 1'b0;
   endtask

   function automatic logic [7:0] pat(input int i);
      logic [7:0] v;
      v = 8'(i + 1);
      return (i % 3 != 2) ? 8'h00 : v;
   endfunction

   initial begin
      int limit;
      reset = 1'b1; enable = 1'b0; rng_byte = 8'h00; out_ready = 1'b1; alarm_clear = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_out_data", out_data, 32'h0);
      chk("rst_alarm", 32'(alarm), 32'h0);
      chk("rst_drop_cnt", 32'(drop_cnt), 32'h0);

      // Ramp: first word after 16 warm-up samples, out_valid two cycles after the 4th collect strobe
      exp_q.push_back(32'h13121110);
      start_run();
      feed_ramp(8'h00, 20);
      #1 chk("latency_low", 32'(out_valid), 32'h0);
      stop_run();
      @(posedge clk);
      #1 chk("latency_high", 32'(out_valid), 32'h1);
      repeat (4) @(posedge clk);

      // Repetition-count trip, alarm clear, then a fresh warm-up
      start_run();
      for (int i = 0; i < 4; i++) feed(8'hA5);
      #1 chk("rct_alarm", 32'(alarm), 32'h1);
      chk("rct_no_valid", 32'(out_valid), 32'h0);
      repeat (20) @(posedge clk);
      #1 chk("fail_sticky", 32'(alarm), 32'h1);
      chk("fail_no_valid", 32'(out_valid), 32'h0);
      @(negedge clk); alarm_clear = 1'b1;
      @(posedge clk);
      @(negedge clk); alarm_clear = 1'b0;
      chk("alarm_cleared", 32'(alarm), 32'h0);
      exp_q.push_back(32'h53525150);
      @(posedge clk);
      feed_ramp(8'h40, 20);
      stop_run();
      repeat (6) @(posedge clk);

      // Stalled sink: four words buffered, two dropped, then drained in order
      out_ready = 1'b0;
      exp_q.push_back(32'h93929190);
      exp_q.push_back(32'h97969594);
      exp_q.push_back(32'h9B9A9998);
      exp_q.push_back(32'h9F9E9D9C);
      start_run();
      feed_ramp(8'h80, 40);
      stop_run();
      repeat (3) @(posedge clk);
      #1 chk("drop_cnt_2", 32'(drop_cnt), 32'd2);
      @(negedge clk); out_ready = 1'b1;
      repeat (10) @(posedge clk);
      #1 chk("drained_3", 32'(exp_q.size()), 32'd0);

      // Full FIFO with pop and push in the same cycle
      out_ready = 1'b0;
      exp_q.push_back(32'hD3D2D1D0);
      exp_q.push_back(32'hD7D6D5D4);
      exp_q.push_back(32'hDBDAD9D8);
      exp_q.push_back(32'hDFDEDDDC);
      exp_q.push_back(32'hE3E2E1E0);
      start_run();
      feed_ramp(8'hC0, 36);
      @(negedge clk); out_ready = 1'b1;
      @(negedge clk); out_ready = 1'b0;
      stop_run();
      repeat (3) @(posedge clk);
      #1 chk("drop_cnt_same", 32'(drop_cnt), 32'd2);
      @(negedge clk); out_ready = 1'b1;
      repeat (10) @(posedge clk);
      #1 chk("drained_4", 32'(exp_q.size()), 32'd0);

      // Partial word discarded by enable=0, re-enable warms up again
      start_run();
      feed_ramp(8'h20, 18);
      stop_run();
      repeat (5) @(posedge clk);
      exp_q.push_back(32'h73727170);
      start_run();
      feed_ramp(8'h60, 20);
      stop_run();
      repeat (6) @(posedge clk);
      #1 chk("drained_5", 32'(exp_q.size()), 32'd0);

      // Reset mid-operation with a buffered word and non-zero drop count
      out_ready = 1'b0;
      start_run();
      feed_ramp(8'h30, 20);
      repeat (2) @(posedge clk);
      #1 chk("pre_reset_valid", 32'(out_valid), 32'h1);
      @(negedge clk); reset = 1'b1; enable = 1'b0;
      @(posedge clk);
      #1 chk("mid_rst_valid", 32'(out_valid), 32'h0);
      chk("mid_rst_data", out_data, 32'h0);
      chk("mid_rst_drop", 32'(drop_cnt), 32'h0);
      chk("mid_rst_alarm", 32'(alarm), 32'h0);
      @(negedge clk); reset = 1'b0; out_ready = 1'b1;
      repeat (2) @(posedge clk);

      // Proportion pattern: 0x00 on 2 of every 3 samples, never a 4-run
`ifdef TRNG_APT_EN
      limit = 56;
`else
      limit = 64;
`endif
      for (int w = 16; w + 3 < limit; w += 4)
         exp_q.push_back({pat(w + 3), pat(w + 2), pat(w + 1), pat(w)});
      start_run();
      for (int i = 0; i < 64; i++) feed(pat(i));
`ifdef TRNG_APT_EN
      #1 chk("apt_alarm", 32'(alarm), 32'h1);
`else
      #1 chk("apt_alarm", 32'(alarm), 32'h0);
`endif
      stop_run();
      @(negedge clk); alarm_clear = 1'b1;
      @(negedge clk); alarm_clear = 1'b0;
      repeat (10) @(posedge clk);
      #1 chk("drained_final", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
